// File: rtl/log_mem_wr_arb_pkg.sv
// ============================================================================
// Module : log_mem_pkg
// Brief  : Shared types and default sizes for the log memory write arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package log_mem_pkg;

  localparam int LOG_DATA_W = 512;
  localparam int LOG_ADDR_W = 10;
  localparam int LOG_DEPTH  = 1 << LOG_ADDR_W;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/log_mem_wr_arb_if.sv
// ============================================================================
// Module : log_mem_wr_arb_if
// Brief  : Requester, memory write, reclaim and status bundle of the log
//          memory write arbiter. slave = arbiter side, master = environment.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface log_mem_wr_arb_if
  import log_mem_pkg::*;
#(
  parameter int DATA_W = LOG_DATA_W,
  parameter int ADDR_W = LOG_ADDR_W
);

  logic              req0_wr_val;
  logic              req0_wr_last;
  logic [DATA_W-1:0] req0_wr_data;
  logic              req0_wr_rdy;

  logic              req1_wr_val;
  logic              req1_wr_last;
  logic [DATA_W-1:0] req1_wr_data;
  logic              req1_wr_rdy;

  logic              mem_wr_val;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_rdy;

  logic              reclaim_val;
  logic [ADDR_W:0]   reclaim_lines;

  logic              log_has_space;
  logic [ADDR_W:0]   log_used;

  modport slave (
    input  req0_wr_val, req0_wr_last, req0_wr_data,
    output req0_wr_rdy,
    input  req1_wr_val, req1_wr_last, req1_wr_data,
    output req1_wr_rdy,
    output mem_wr_val, mem_wr_addr, mem_wr_data,
    input  mem_wr_rdy,
    input  reclaim_val, reclaim_lines,
    output log_has_space, log_used
  );

  modport master (
    output req0_wr_val, req0_wr_last, req0_wr_data,
    input  req0_wr_rdy,
    output req1_wr_val, req1_wr_last, req1_wr_data,
    input  req1_wr_rdy,
    input  mem_wr_val, mem_wr_addr, mem_wr_data,
    output mem_wr_rdy,
    output reclaim_val, reclaim_lines,
    input  log_has_space, log_used
  );

endinterface

`default_nettype wire

// File: rtl/log_mem_wr_arb_space_tracker.sv
// ============================================================================
// Module : log_space_tracker
// Brief  : Owns the log write pointer and occupancy count. Accepted beats
//          advance the pointer and grow occupancy; reclaims shrink it, with
//          an over-reclaim clamped to zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module log_space_tracker
  import log_mem_pkg::*;
#(
  parameter int ADDR_W = LOG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_acc,
  input  logic              i_reclaim_val,
  input  logic [ADDR_W:0]   i_reclaim_lines,
  output logic [ADDR_W-1:0] o_wr_ptr,
  output logic [ADDR_W:0]   o_used,
  output logic              o_has_space
);

  localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_used;
  logic [ADDR_W:0]   w_used_inc;
  logic [ADDR_W:0]   w_reclaim;
  logic [ADDR_W:0]   w_used_nxt;

  // Occupancy after this cycle's write (never exceeds DEPTH: writes need space)
  // minus this cycle's reclaim, clamped at zero on over-reclaim.
  always_comb begin
    w_used_inc = r_used + {{ADDR_W{1'b0}}, i_wr_acc};
    w_reclaim  = i_reclaim_val ? i_reclaim_lines : '0;
    if (w_reclaim > w_used_inc) begin
      w_used_nxt = '0;
    end else begin
      w_used_nxt = w_used_inc - w_reclaim;
    end
  end

  // Pointer wraps naturally through its width; occupancy follows the sum above.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_used   <= '0;
    end else begin
      if (i_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      r_used <= w_used_nxt;
    end
  end

  // Status is forced to its reset view while rst is held.
  assign o_wr_ptr    = r_wr_ptr;
  assign o_used      = rst ? '0 : r_used;
  assign o_has_space = rst | (r_used != c_DEPTH);

endmodule

`default_nettype wire

// File: rtl/log_mem_wr_arb.sv
// ============================================================================
// Module : log_mem_wr_arb
// Brief  : Arbitrates two multi-beat log writers (prepare, state-transfer)
//          onto one log memory write port. Grants are held for a whole
//          entry; ties alternate. Optional macro LOG_ARB_STATS_EN adds
//          per-requester accepted-beat counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module log_mem_wr_arb
  import log_mem_pkg::*;
#(
  parameter int DATA_W = LOG_DATA_W,
  parameter int ADDR_W = LOG_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  log_mem_wr_arb_if.slave        bus
`ifdef LOG_ARB_STATS_EN
  ,
  output logic [31:0]            req0_beats,
  output logic [31:0]            req1_beats
`endif
);

  localparam logic [1:0] S_IDLE   = ARB_IDLE;
  localparam logic [1:0] S_GRANT0 = ARB_GRANT0;
  localparam logic [1:0] S_GRANT1 = ARB_GRANT1;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_last_grant;
  logic              w_last_grant_nxt;
  logic              w_has_space;
  logic [ADDR_W:0]   w_used;
  logic [ADDR_W-1:0] w_wr_ptr;
  logic              w_sel1;
  logic              w_granted;
  logic              w_req_val;
  logic              w_req_last;
  logic [DATA_W-1:0] w_req_data;
  logic              w_mem_val;
  logic              w_acc;

  // Granted-requester mux; forwarding only once a grant is held and space exists.
  always_comb begin
    w_sel1     = (r_state == S_GRANT1);
    w_granted  = (r_state == S_GRANT0) || (r_state == S_GRANT1);
    w_req_val  = w_sel1 ? bus.req1_wr_val  : bus.req0_wr_val;
    w_req_last = w_sel1 ? bus.req1_wr_last : bus.req0_wr_last;
    w_req_data = w_sel1 ? bus.req1_wr_data : bus.req0_wr_data;
    w_mem_val  = ~rst & w_granted & w_req_val & w_has_space;
    w_acc      = w_mem_val & bus.mem_wr_rdy;
  end

  assign bus.mem_wr_val    = w_mem_val;
  assign bus.mem_wr_addr   = w_wr_ptr;
  assign bus.mem_wr_data   = w_req_data;
  assign bus.req0_wr_rdy   = ~rst & (r_state == S_GRANT0) & bus.mem_wr_rdy & w_has_space;
  assign bus.req1_wr_rdy   = ~rst & (r_state == S_GRANT1) & bus.mem_wr_rdy & w_has_space;
  assign bus.log_has_space = w_has_space;
  assign bus.log_used      = w_used;

  // Next grant: IDLE picks a requester (tie goes away from last_grant);
  // a grant is released only by an accepted last beat.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      S_IDLE: begin
        if (bus.req0_wr_val && bus.req1_wr_val) begin
          if (r_last_grant) begin
            w_state_nxt      = S_GRANT0;
            w_last_grant_nxt = 1'b0;
          end else begin
            w_state_nxt      = S_GRANT1;
            w_last_grant_nxt = 1'b1;
          end
        end else if (bus.req0_wr_val) begin
          w_state_nxt      = S_GRANT0;
          w_last_grant_nxt = 1'b0;
        end else if (bus.req1_wr_val) begin
          w_state_nxt      = S_GRANT1;
          w_last_grant_nxt = 1'b1;
        end
      end
      S_GRANT0, S_GRANT1: begin
        if (w_acc && w_req_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Arbiter state; reset makes req0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  log_space_tracker #(
    .ADDR_W (ADDR_W)
  ) u_space (
    .clk             (clk),
    .rst             (rst),
    .i_wr_acc        (w_acc),
    .i_reclaim_val   (bus.reclaim_val),
    .i_reclaim_lines (bus.reclaim_lines),
    .o_wr_ptr        (w_wr_ptr),
    .o_used          (w_used),
    .o_has_space     (w_has_space)
  );

`ifdef LOG_ARB_STATS_EN
  logic [31:0] r_req0_beats;
  logic [31:0] r_req1_beats;

  // Accepted-beat counters per requester, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req0_beats <= '0;
      r_req1_beats <= '0;
    end else if (w_acc) begin
      if (w_sel1) begin
        r_req1_beats <= r_req1_beats + 32'd1;
      end else begin
        r_req0_beats <= r_req0_beats + 32'd1;
      end
    end
  end

  assign req0_beats = r_req0_beats;
  assign req1_beats = r_req1_beats;
`endif

endmodule

`default_nettype wire
